// File: rtl/rv_decode_stage.sv
// rv_decode_stage: clocked RISC-V decode stage with a small output FIFO.
// Instructions arrive with their PC over a valid/ready handshake.
// Each one is decoded combinationally. On accept, the decoded entry is
// pushed into a DEPTH-entry FIFO that feeds the execute stage.
module rv_decode_stage #(
  parameter int XLEN     = 64,
  parameter bit ENABLE_M = 1'b1,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_class,
  output logic [4:0]      out_funct,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [3:0] {
    CLS_ILLEGAL   = 4'd0,
    CLS_OP        = 4'd1,
    CLS_OP_IMM    = 4'd2,
    CLS_LOAD      = 4'd3,
    CLS_STORE     = 4'd4,
    CLS_BRANCH    = 4'd5,
    CLS_LUI       = 4'd6,
    CLS_AUIPC     = 4'd7,
    CLS_JAL       = 4'd8,
    CLS_JALR      = 4'd9,
    CLS_OP_32     = 4'd10,
    CLS_OP_IMM_32 = 4'd11,
    CLS_SYSTEM    = 4'd12
  } cls_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [4:0]      funct;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       is64;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign is64   = (XLEN == 64);

  cls_e            cls;
  logic            shift_imm;
  logic [31:0]     imm32;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm_x;
  entry_t          dec;

  // Classify the instruction and flag any illegal encoding.
  always_comb begin
    cls       = CLS_ILLEGAL;
    shift_imm = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: begin
          if (f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
              (f7 == 7'b0000001 && ENABLE_M))
            cls = CLS_OP;
        end
        7'b0111011: begin
          if (is64 &&
              ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
               (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
               (f7 == 7'b0000001 && ENABLE_M && f3 != 3'b001 && f3 != 3'b010 && f3 != 3'b011)))
            cls = CLS_OP_32;
        end
        7'b0010011: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            shift_imm = 1'b1;
            if ((in_instr[31:26] == 6'b000000 ||
                 (f3 == 3'b101 && in_instr[31:26] == 6'b010000)) &&
                (is64 || !in_instr[25]))
              cls = CLS_OP_IMM;
          end else begin
            cls = CLS_OP_IMM;
          end
        end
        7'b0011011: begin
          if (is64) begin
            if (f3 == 3'b000) begin
              cls = CLS_OP_IMM_32;
            end else if (f3 == 3'b001 || f3 == 3'b101) begin
              shift_imm = 1'b1;
              if (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000))
                cls = CLS_OP_IMM_32;
            end
          end
        end
        7'b0000011: begin
          if (f3 != 3'b111 && (is64 || (f3 != 3'b011 && f3 != 3'b110)))
            cls = CLS_LOAD;
        end
        7'b0100011: begin
          if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || (is64 && f3 == 3'b011))
            cls = CLS_STORE;
        end
        7'b1100011: begin
          if (f3 != 3'b010 && f3 != 3'b011)
            cls = CLS_BRANCH;
        end
        7'b1100111: begin
          if (f3 == 3'b000)
            cls = CLS_JALR;
        end
        7'b0110111: cls = CLS_LUI;
        7'b0010111: cls = CLS_AUIPC;
        7'b1101111: cls = CLS_JAL;
        7'b1110011: begin
          if (f3 == 3'b000) begin
            if (in_instr == 32'h0000_0073 || in_instr == 32'h0010_0073)
              cls = CLS_SYSTEM;
          end else if (f3 != 3'b100) begin
            cls = CLS_SYSTEM;
          end
        end
        default: cls = CLS_ILLEGAL;
      endcase
    end
  end

  // Build the sign-extended immediate and the rest of the decoded entry.
  always_comb begin
    imm32 = '0;
    case (cls)
      CLS_LOAD, CLS_OP_IMM, CLS_JALR, CLS_OP_IMM_32:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      CLS_STORE:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      CLS_BRANCH:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm32 = {in_instr[31:12], 12'b0};
      CLS_JAL:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    shamt = is64 ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    if (shift_imm && cls != CLS_ILLEGAL)
      imm_x = {{(XLEN-6){1'b0}}, shamt};
    else
      imm_x = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    dec          = '0;
    dec.pc       = in_pc;
    dec.cls      = cls;
    dec.rd       = rd;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.imm      = imm_x;
    dec.illegal  = (cls == CLS_ILLEGAL);
    dec.funct[2:0] = f3;
    dec.funct[4] = in_instr[30] & (cls == CLS_OP || cls == CLS_OP_32 ||
                                   (shift_imm && cls != CLS_ILLEGAL));
    dec.funct[3] = in_instr[25] & (cls == CLS_OP || cls == CLS_OP_32);
    dec.rd_we    = (rd != 5'd0) &&
                   (cls == CLS_OP || cls == CLS_OP_IMM || cls == CLS_LOAD ||
                    cls == CLS_LUI || cls == CLS_AUIPC || cls == CLS_JAL ||
                    cls == CLS_JALR || cls == CLS_OP_32 || cls == CLS_OP_IMM_32 ||
                    (cls == CLS_SYSTEM && f3 != 3'b000));
    dec.target   = (cls == CLS_BRANCH || cls == CLS_JAL) ? in_pc + imm_x : '0;
  end

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  entry_t         head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  // Output FIFO storage and occupancy; flush empties it and drops any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Saturating tally of illegal instructions that actually entered the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (push && dec.illegal && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  assign out_pc      = head.pc;
  assign out_class   = head.cls;
  assign out_funct   = head.funct;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd_we   = head.rd_we;
  assign out_imm     = head.imm;
  assign out_target  = head.target;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed-vector bench for rv_decode_stage.
// Three instances share one input stream: RV64 with M, RV32 with M, and RV64 without M.
module tb_rv_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        rdy64, val64, rwe64, ill64;
  logic [63:0] pc64, imm64, tgt64;
  logic [3:0]  cls64;
  logic [4:0]  fn64, rd64, rs164, rs264;
  logic [15:0] cnt64;

  logic        rdy32, val32, rwe32, ill32;
  logic [31:0] pc32, imm32, tgt32;
  logic [3:0]  cls32;
  logic [4:0]  fn32, rd32, rs132, rs232;
  logic [15:0] cnt32;

  logic        rdynm, valnm, rwenm, illnm;
  logic [63:0] pcnm, immnm, tgtnm;
  logic [3:0]  clsnm;
  logic [4:0]  fnnm, rdnm, rs1nm, rs2nm;
  logic [15:0] cntnm;

  int checks = 0;
  int errors = 0;

  rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(val64), .out_ready(out_ready),
    .out_pc(pc64), .out_class(cls64), .out_funct(fn64), .out_rd(rd64),
    .out_rs1(rs164), .out_rs2(rs264), .out_rd_we(rwe64), .out_imm(imm64),
    .out_target(tgt64), .out_illegal(ill64), .illegal_cnt(cnt64));

  rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(val32), .out_ready(out_ready),
    .out_pc(pc32), .out_class(cls32), .out_funct(fn32), .out_rd(rd32),
    .out_rs1(rs132), .out_rs2(rs232), .out_rd_we(rwe32), .out_imm(imm32),
    .out_target(tgt32), .out_illegal(ill32), .illegal_cnt(cnt32));

  rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b0), .DEPTH(2)) dutnm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdynm),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(valnm), .out_ready(out_ready),
    .out_pc(pcnm), .out_class(clsnm), .out_funct(fnnm), .out_rd(rdnm),
    .out_rs1(rs1nm), .out_rs2(rs2nm), .out_rd_we(rwenm), .out_imm(immnm),
    .out_target(tgtnm), .out_illegal(illnm), .illegal_cnt(cntnm));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at the next negedge,
  // when an instruction accepted into an empty FIFO sits at the head.
  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Directed vectors, hand-decoded expectations, FIFO and flush scenarios.
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", {63'd0, val64}, 64'd0);
    checkOutput("rst_ready", {63'd0, rdy64}, 64'd1);
    checkOutput("rst_cnt", {48'd0, cnt64}, 64'd0);
    checkOutput("rst_pc", pc64, 64'd0);
    checkOutput("rst_class", {60'd0, cls64}, 64'd0);

    // add x1,x2,x3
    applyStimulus(32'h003100B3, 64'h1000);
    checkOutput("add_valid", {63'd0, val64}, 64'd1);
    checkOutput("add_class", {60'd0, cls64}, 64'd1);
    checkOutput("add_funct", {59'd0, fn64}, 64'd0);
    checkOutput("add_rd", {59'd0, rd64}, 64'd1);
    checkOutput("add_rs1", {59'd0, rs164}, 64'd2);
    checkOutput("add_rs2", {59'd0, rs264}, 64'd3);
    checkOutput("add_rdwe", {63'd0, rwe64}, 64'd1);
    checkOutput("add_pc", pc64, 64'h1000);

    // beq x1,x2,-8
    applyStimulus(32'hFE208CE3, 64'h1000);
    checkOutput("beq_class", {60'd0, cls64}, 64'd5);
    checkOutput("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("beq_target", tgt64, 64'hFF8);
    checkOutput("beq_rdwe", {63'd0, rwe64}, 64'd0);
    checkOutput("beq_imm32", {32'd0, imm32}, 64'hFFFF_FFF8);
    checkOutput("beq_target32", {32'd0, tgt32}, 64'hFF8);

    // lui x1,0x80000
    applyStimulus(32'h800000B7, 64'h1004);
    checkOutput("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    checkOutput("lui_imm32", {32'd0, imm32}, 64'h8000_0000);
    checkOutput("lui_class", {60'd0, cls64}, 64'd6);
    checkOutput("lui_tgt", tgt64, 64'd0);

    // ld x5,16(x2)
    applyStimulus(32'h01013283, 64'h1008);
    checkOutput("ld_class64", {60'd0, cls64}, 64'd3);
    checkOutput("ld_imm64", imm64, 64'd16);
    checkOutput("ld_ill64", {63'd0, ill64}, 64'd0);
    checkOutput("ld_ill32", {63'd0, ill32}, 64'd1);
    checkOutput("ld_class32", {60'd0, cls32}, 64'd0);
    checkOutput("ld_rdwe32", {63'd0, rwe32}, 64'd0);
    checkOutput("ld_cnt32", {48'd0, cnt32}, 64'd1);

    // mul x1,x2,x3
    applyStimulus(32'h023100B3, 64'h100C);
    checkOutput("mul_class64", {60'd0, cls64}, 64'd1);
    checkOutput("mul_funct64", {59'd0, fn64}, 64'h08);
    checkOutput("mul_illnm", {63'd0, illnm}, 64'd1);
    checkOutput("mul_classnm", {60'd0, clsnm}, 64'd0);
    checkOutput("mul_rdwenm", {63'd0, rwenm}, 64'd0);
    checkOutput("mul_cntnm", {48'd0, cntnm}, 64'd1);

    // sw x5,8(x2)
    applyStimulus(32'h00512423, 64'h1010);
    checkOutput("sw_class", {60'd0, cls64}, 64'd4);
    checkOutput("sw_imm", imm64, 64'd8);
    checkOutput("sw_rdwe", {63'd0, rwe64}, 64'd0);

    // jal x1,+16
    applyStimulus(32'h010000EF, 64'h2000);
    checkOutput("jal_class", {60'd0, cls64}, 64'd8);
    checkOutput("jal_imm", imm64, 64'd16);
    checkOutput("jal_target", tgt64, 64'h2010);
    checkOutput("jal_rdwe", {63'd0, rwe64}, 64'd1);

    // srai x1,x2,3
    applyStimulus(32'h40315093, 64'h2004);
    checkOutput("srai_class", {60'd0, cls64}, 64'd2);
    checkOutput("srai_funct", {59'd0, fn64}, 64'h15);
    checkOutput("srai_imm", imm64, 64'd3);
    checkOutput("srai_class32", {60'd0, cls32}, 64'd2);

    // ecall
    applyStimulus(32'h00000073, 64'h2008);
    checkOutput("ecall_class", {60'd0, cls64}, 64'd12);
    checkOutput("ecall_rdwe", {63'd0, rwe64}, 64'd0);

    // all-zero word: low bits not 11
    applyStimulus(32'h00000000, 64'h200C);
    checkOutput("zero_ill", {63'd0, ill64}, 64'd1);
    checkOutput("zero_tgt", tgt64, 64'd0);
    checkOutput("zero_cnt64", {48'd0, cnt64}, 64'd1);
    checkOutput("zero_cnt32", {48'd0, cnt32}, 64'd2);
    checkOutput("zero_cntnm", {48'd0, cntnm}, 64'd2);

    // jal +16 from near the top of the address space wraps
    applyStimulus(32'h010000EF, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("wrap_tgt64", tgt64, 64'h8);
    checkOutput("wrap_tgt32", {32'd0, tgt32}, 64'h8);

    // Back-pressure: fill the two-entry FIFO, then drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'h003100B3; in_pc = 64'h100;
    @(negedge clk);
    checkOutput("bp_ready1", {63'd0, rdy64}, 64'd1);
    in_instr = 32'h00512423; in_pc = 64'h104;
    @(negedge clk);
    checkOutput("bp_full", {63'd0, rdy64}, 64'd0);
    in_instr = 32'h010000EF; in_pc = 64'h108;
    @(negedge clk);
    checkOutput("bp_still_full", {63'd0, rdy64}, 64'd0);
    checkOutput("bp_head_hold", pc64, 64'h100);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_reassert", {63'd0, rdy64}, 64'd1);
    checkOutput("bp_head2", pc64, 64'h104);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_head3", pc64, 64'h108);
    checkOutput("bp_head3_cls", {60'd0, cls64}, 64'd8);
    @(negedge clk);
    checkOutput("bp_empty", {63'd0, val64}, 64'd0);

    // Flush with a full FIFO and a pending push.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 64'h300;
    @(negedge clk);
    in_pc = 64'h304;
    @(negedge clk);
    flush = 1'b1; in_instr = 32'h00000000; in_pc = 64'h308;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl_valid", {63'd0, val64}, 64'd0);
    checkOutput("fl_ready", {63'd0, rdy64}, 64'd1);
    checkOutput("fl_cnt", {48'd0, cnt64}, 64'd1);
    @(negedge clk);
    checkOutput("fl_valid2", {63'd0, val64}, 64'd0);

    // Flush with one entry while a push is offered: the push is dropped.
    in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 64'h400;
    @(negedge clk);
    flush = 1'b1; in_pc = 64'h404;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl2_valid", {63'd0, val64}, 64'd0);
    applyStimulus(32'h003100B3, 64'h410);
    checkOutput("fl2_next_pc", pc64, 64'h410);
    checkOutput("fl2_next_valid", {63'd0, val64}, 64'd1);

    // Asynchronous reset in the middle of a stalled entry.
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {63'd0, val64}, 64'd0);
    checkOutput("ar_cnt", {48'd0, cnt64}, 64'd0);
    checkOutput("ar_pc", pc64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ar_ready", {63'd0, rdy64}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
